load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the word-wide data memory interface: accepts RV32I load/store requests from the execute stage and drives mem_read/mem_write/addr/write_data.
- Performs byte/halfword extraction with sign/zero extension on loads.
- The memory has no byte enables, so sub-word stores use read-modify-write.
- Sits between the execute stage and data_memory; one transaction in flight.

Parameters:
- ADDR_W, 32, byte address width; memory word index is addr[ADDR_W-1:2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (size/signedness)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_fault  out  1  misaligned or illegal funct3
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned byte address (low 2 bits always 0)
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data, valid only while mem_read=1

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - All outputs 0 except req_ready, which is 1 once reset is released.
  - Internal latches are cleared.
- Handshake:
  - A request is accepted when req_valid & req_ready at a clk edge; all req_* fields are latched.
  - The response is held stable while resp_valid & !resp_ready.
  - The response completes on resp_valid & resp_ready.
  - req_ready stays 0 from acceptance until the response completes.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE, on accept:
  - Illegal funct3 -> RESP with fault. Illegal loads: 011, 110, 111. Illegal stores: any value > 010.
  - Misaligned -> RESP with fault. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Legal load -> LOAD.
  - SW -> WRITE.
  - SB/SH -> RMW_RD.
- LOAD:
  - mem_read=1.
  - Capture extended mem_rdata into resp_rdata.
  - Next state RESP.
- RMW_RD:
  - mem_read=1.
  - Capture merged word into mem_wdata: the selected byte/half lane is replaced by req_wdata[7:0]/[15:0].
  - Next state WRITE.
- WRITE:
  - mem_write=1 for exactly one cycle.
  - Next state RESP.
- RESP:
  - resp_valid=1.
  - On resp_ready, return to IDLE; req_ready rises the following cycle.
- mem_read and mem_write are never high together, and are 0 in IDLE and RESP.
- mem_addr = {latched_addr[ADDR_W-1:2],2'b00} in active states; 0 in IDLE.
- Latency, from the accept edge T to resp_valid:
  - Load: T+2.
  - SW: T+2.
  - SB/SH: T+3.
  - Fault: T+1, with no memory access.
- Lane select: byte lane addr[1:0]; half lane addr[1].
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Fault responses have resp_rdata=0.
- Reset mid-transaction (e.g. in WRITE before the edge): mem_write drops immediately, memory is untouched, and no response is produced.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: misaligned requests fault as described above.
- Undefined:
  - No alignment check; resp_fault is set only for illegal funct3.
  - Lane/half selection uses the address bits as-is: a half at offset 1 or 3 rounds down to the aligned half via addr[1]; a word ignores addr[1:0].

Decomposition:
- Package lsu_pkg contains:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - lsu_state_t enum.
  - Function is_legal_funct3(store, f3).
- One sub-module, lsu_align, purely combinational:
  - load_extract(word, addr[1:0], funct3) -> 32-bit extended data.
  - store_merge(old_word, wdata, addr[1:0], funct3) -> merged word.

Test Plan:
- SW addr 0x100 data 0x8899AABB -> one mem_write cycle at mem_addr 0x100; resp_valid at T+2, resp_fault=0; memory word = 0x8899AABB.
- After the above, LB 0x101 -> resp_rdata 0xFFFFFFAA; LBU 0x101 -> 0x000000AA; LH 0x102 -> 0xFFFF8899; LHU 0x102 -> 0x00008899; each at T+2.
- SB 0x103 data 0xFFFFFF11 -> mem_read at T+1, mem_write at T+2 with mem_wdata 0x1199AABB, resp at T+3; a later LW 0x100 returns 0x1199AABB.
- LW 0x102 with macro defined -> resp_fault=1 at T+1, resp_rdata=0, mem_read and mem_write never asserted. Load funct3=3'b111 -> fault in both builds.
- LW 0x100 with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; completes on the first resp_ready=1 edge.
- SH 0x100 with rst_n pulsed low during WRITE -> mem_write drops asynchronously, memory word unchanged, FSM returns to IDLE, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// and request legality/alignment checks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    function automatic logic is_legal_funct3(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Size lives in f3[1:0] for every legal encoding (00 byte, 01 half, 10 word).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
               ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request/response handshake plus word-wide data memory bus.
// The slave modport is the load/store unit's view; master is the surrounding system.
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension, and
// byte/half merge into an old word for read-modify-write stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte  = rd_word[8*addr_lo +: 8];
        sel_half  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // Each byte lane decides independently whether the store covers it.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        localparam logic       HALF = 1'(gi >> 1);
        logic       lane_hit;
        logic [7:0] lane_src;

        always_comb begin
            lane_hit = 1'b1;
            lane_src = wdata[8*gi +: 8];
            case (funct3[1:0])
                2'b00: begin
                    lane_hit = (addr_lo == LANE);
                    lane_src = wdata[7:0];
                end
                2'b01: begin
                    lane_hit = (addr_lo[1] == HALF);
                    lane_src = wdata[8*(gi % 2) +: 8];
                end
                default: begin
                    lane_hit = 1'b1;
                    lane_src = wdata[8*gi +: 8];
                end
            endcase
        end

        assign merged_word[8*gi +: 8] = lane_hit ? lane_src : rd_word[8*gi +: 8];
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-wide memory without byte enables.
// Optional alignment faulting is enabled with the LSU_MISALIGN_CHECK_EN macro.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    lsu_state_t        state_reg;
    logic [2:0]        f3_reg;
    logic [1:0]        addr_lo_reg;
    logic [31:0]       wdata_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic              resp_fault_reg;
    logic [31:0]       resp_rdata_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    logic [31:0]       load_data;
    logic [31:0]       merged_word;
    logic              req_fault;

    lsu_align u_align (
        .rd_word     (bus.mem_rdata),
        .wdata       (wdata_reg),
        .addr_lo     (addr_lo_reg),
        .funct3      (f3_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        req_fault = !is_legal_funct3(bus.req_store, bus.req_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
        req_fault = req_fault | is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            f3_reg         <= '0;
            addr_lo_reg    <= '0;
            wdata_reg      <= '0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_fault_reg <= 1'b0;
            resp_rdata_reg <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (bus.req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        f3_reg        <= bus.req_funct3;
                        addr_lo_reg   <= bus.req_addr[1:0];
                        wdata_reg     <= bus.req_wdata;
                        mem_addr_reg  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        if (req_fault) begin
                            resp_valid_reg <= 1'b1;
                            resp_fault_reg <= 1'b1;
                            resp_rdata_reg <= '0;
                            state_reg      <= ST_RESP;
                        end else if (!bus.req_store) begin
                            mem_read_reg <= 1'b1;
                            state_reg    <= ST_LOAD;
                        end else if (bus.req_funct3 == F3_W) begin
                            mem_write_reg <= 1'b1;
                            mem_wdata_reg <= bus.req_wdata;
                            state_reg     <= ST_WRITE;
                        end else begin
                            mem_read_reg <= 1'b1;
                            state_reg    <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    mem_read_reg   <= 1'b0;
                    resp_rdata_reg <= load_data;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    mem_read_reg  <= 1'b0;
                    mem_wdata_reg <= merged_word;
                    mem_write_reg <= 1'b1;
                    state_reg     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_write_reg  <= 1'b0;
                    resp_rdata_reg <= '0;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_fault_reg <= 1'b0;
                        resp_rdata_reg <= '0;
                        mem_addr_reg   <= '0;
                        mem_wdata_reg  <= '0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_fault = resp_fault_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.mem_read   = mem_read_reg;
    assign bus.mem_write  = mem_write_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of transactions against a
// word memory model, plus stall and mid-transaction reset sequences.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clear = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[9:2]] : 32'h0;

    always @(negedge clk) begin
        if (rst_n && bus.mem_read && bus.mem_write) begin
            errors++;
            $display("FAIL bus_exclusive: mem_read=%b mem_write=%b required not both 1",
                     bus.mem_read, bus.mem_write);
        end
        if (rst_n && bus.mem_addr[1:0] != 2'b00) begin
            errors++;
            $display("FAIL mem_addr_align: got %h required low bits 00", bus.mem_addr);
        end
    end

    typedef struct {
        string       name;
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(string n, logic st, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] wd, logic [31:0] er, logic ef, int el,
                                 int rd, int wr, logic [31:0] ewd);
        vec_t v;
        v.name = n; v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el;
        v.exp_reads = rd; v.exp_writes = wr; v.exp_wdata = ewd;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check32({name, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    endtask

    task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic run_txn(input vec_t v);
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] wd;
        bit          got;
        wait_ready(v.name);
        drive_req(v.store, v.f3, v.addr, v.wdata);
        @(posedge clk);
        lat = 0; reads = 0; writes = 0; wd = 32'h0; got = 1'b0;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.mem_read) reads++;
            if (bus.mem_write) begin
                writes++;
                wd = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        $display("txn %-10s store=%b f3=%b addr=%h lat=%0d rdata=%h fault=%b reads=%0d writes=%0d",
                 v.name, v.store, v.f3, v.addr, lat, bus.resp_rdata, bus.resp_fault, reads, writes);
        check32({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check32({v.name, "_fault"}, {31'h0, bus.resp_fault}, {31'h0, v.exp_fault});
        check32({v.name, "_rdata"}, bus.resp_rdata, v.exp_rdata);
        check32({v.name, "_reads"}, 32'(reads), 32'(v.exp_reads));
        check32({v.name, "_writes"}, 32'(writes), 32'(v.exp_writes));
        check32({v.name, "_busy"}, {31'h0, bus.req_ready}, 32'h0);
        if (v.exp_writes > 0) check32({v.name, "_wdata"}, wd, v.exp_wdata);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check32({v.name, "_done"}, {30'h0, bus.resp_valid, bus.req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] stall_rdata;
        bit          seen;
        bit          any_resp;
        int          w;

        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;

        vecs.push_back(mkv("SW100", 1, F3_W, 32'h100, 32'h8899AABB, 32'h0, 0, 2, 0, 1, 32'h8899AABB));
        vecs.push_back(mkv("LB101", 0, F3_B, 32'h101, 32'h0, 32'hFFFFFFAA, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LBU101", 0, F3_BU, 32'h101, 32'h0, 32'h000000AA, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LH102", 0, F3_H, 32'h102, 32'h0, 32'hFFFF8899, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LHU102", 0, F3_HU, 32'h102, 32'h0, 32'h00008899, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("SB103", 1, F3_B, 32'h103, 32'hFFFFFF11, 32'h0, 0, 3, 1, 1, 32'h1199AABB));
        vecs.push_back(mkv("LW100", 0, F3_W, 32'h100, 32'h0, 32'h1199AABB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LB100", 0, F3_B, 32'h100, 32'h0, 32'hFFFFFFBB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LBU102", 0, F3_BU, 32'h102, 32'h0, 32'h00000099, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("SH106", 1, F3_H, 32'h106, 32'h1234ABCD, 32'h0, 0, 3, 1, 1, 32'hABCD0000));
        vecs.push_back(mkv("LH106", 0, F3_H, 32'h106, 32'h0, 32'hFFFFABCD, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LHU104", 0, F3_HU, 32'h104, 32'h0, 32'h00000000, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LD_F3_111", 0, 3'b111, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("LD_F3_011", 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("ST_F3_011", 1, 3'b011, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("ST_F3_100", 1, 3'b100, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1, 0, 0, 32'h0));
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mkv("LW102", 0, F3_W, 32'h102, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("LH101", 0, F3_H, 32'h101, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("SW10A", 1, F3_W, 32'h10A, 32'h77776666, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("SH105", 1, F3_H, 32'h105, 32'h0000BEEF, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("LW104", 0, F3_W, 32'h104, 32'h0, 32'hABCD0000, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LW108", 0, F3_W, 32'h108, 32'h0, 32'h00000000, 0, 2, 1, 0, 32'h0));
`else
        vecs.push_back(mkv("LW102", 0, F3_W, 32'h102, 32'h0, 32'h1199AABB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LH101", 0, F3_H, 32'h101, 32'h0, 32'hFFFFAABB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("SW10A", 1, F3_W, 32'h10A, 32'h77776666, 32'h0, 0, 2, 0, 1, 32'h77776666));
        vecs.push_back(mkv("SH105", 1, F3_H, 32'h105, 32'h0000BEEF, 32'h0, 0, 3, 1, 1, 32'hABCDBEEF));
        vecs.push_back(mkv("LW104", 0, F3_W, 32'h104, 32'h0, 32'hABCDBEEF, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mkv("LW108", 0, F3_W, 32'h108, 32'h0, 32'h77776666, 0, 2, 1, 0, 32'h0));
`endif

        // Reset state while rst_n is held low
        #12;
        check32("reset_ctrl", {27'h0, bus.req_ready, bus.resp_valid, bus.resp_fault,
                               bus.mem_read, bus.mem_write}, 32'h0);
        check32("reset_mem_addr", bus.mem_addr, 32'h0);
        check32("reset_mem_wdata", bus.mem_wdata, 32'h0);
        check32("reset_resp_rdata", bus.resp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check32("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

        check32("mem_word_100", mem[8'h40], 32'h1199AABB);

        // Response held under back-pressure
        wait_ready("stall");
        drive_req(1'b0, F3_W, 32'h100, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        w = 0;
        while (!bus.resp_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check32("stall_first_valid", {31'h0, bus.resp_valid}, 32'h1);
        stall_rdata = bus.resp_rdata;
        check32("stall_rdata", stall_rdata, 32'h1199AABB);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check32("stall_hold", {bus.resp_valid, bus.req_ready, 30'h0} ^ {2'b10, 30'h0}
                    ^ (bus.resp_rdata ^ 32'h1199AABB), 32'h0);
        end
        $display("txn stall      LW addr=00000100 held 5 cycles rdata=%h", bus.resp_rdata);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check32("stall_release", {31'h0, bus.resp_valid}, 32'h0);

        // Reset pulsed while the RMW write is on the bus
        wait_ready("rst_mid");
        drive_req(1'b1, F3_H, 32'h100, 32'h00005555);
        @(posedge clk);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.mem_write) seen = 1'b1;
        end
        check32("rst_mid_write_seen", {31'h0, seen}, 32'h1);
        rst_n = 1'b0;
        #1;
        check32("rst_mid_write_drop", {31'h0, bus.mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check32("rst_mid_mem_untouched", mem[8'h40], 32'h1199AABB);
        rst_n = 1'b1;
        any_resp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid) any_resp = 1'b1;
        end
        $display("txn rst_mid    SH addr=00000100 mem=%h resp_seen=%b", mem[8'h40], any_resp);
        check32("rst_mid_no_resp", {31'h0, any_resp}, 32'h0);
        check32("rst_mid_idle", {31'h0, bus.req_ready}, 32'h1);

        run_txn(mkv("LW100_post", 0, F3_W, 32'h100, 32'h0, 32'h1199AABB, 0, 2, 1, 0, 32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
